// File: rtl/st_fifo_8_if.sv
// Avalon-ST valid/ready bundle for st_fifo_8: upstream (in_*) and downstream (out_*) sides.
interface st_fifo_8_if #(
  parameter int unsigned DATA_W = 8
);
  logic [DATA_W-1:0] in_data;
  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] out_data;
  logic              out_valid;
  logic              out_ready;

  modport slave (
    input  in_data, in_valid, out_ready,
    output in_ready, out_data, out_valid
  );

  modport master (
    output in_data, in_valid, out_ready,
    input  in_ready, out_data, out_valid
  );
endinterface

// File: rtl/st_fifo_8.sv
// Synchronous show-ahead FIFO with Avalon-ST valid/ready on both sides.
// Flow control depends only on registered occupancy, never on out_ready.
module st_fifo_8 #(
  parameter  int unsigned DATA_W = 8,
  parameter  int unsigned DEPTH  = 8,
  localparam int unsigned CNT_W  = $clog2(DEPTH) + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  st_fifo_8_if.slave       st,
  output logic [CNT_W-1:0] level,
  output logic             full,
  output logic             empty
);
  localparam int unsigned PTR_W = $clog2(DEPTH);

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [DATA_W-1:0] mem_d [DEPTH];
  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [CNT_W-1:0]  level_q, level_d;
  logic              wr_en, rd_en;

  assign full  = (level_q == CNT_W'(DEPTH));
  assign empty = (level_q == '0);
  assign level = level_q;

  assign st.in_ready  = !full;
  assign st.out_valid = !empty;
  assign st.out_data  = empty ? '0 : mem_q[rd_ptr_q];

  // Handshakes are void in a reset/flush cycle so no word survives the clear.
  assign wr_en = st.in_valid && !full && !rst && !flush;
  assign rd_en = !empty && st.out_ready && !rst && !flush;

  always_comb begin
    mem_d    = mem_q;
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    level_d  = level_q;
    if (wr_en) begin
      mem_d[wr_ptr_q] = st.in_data;
      wr_ptr_d        = wr_ptr_q + PTR_W'(1);
    end
    if (rd_en) begin
      rd_ptr_d = rd_ptr_q + PTR_W'(1);
    end
    case ({wr_en, rd_en})
      2'b10:   level_d = level_q + CNT_W'(1);
      2'b01:   level_d = level_q - CNT_W'(1);
      default: level_d = level_q;
    endcase
    if (rst || flush) begin
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      level_d  = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      level_q  <= level_d;
    end
  end

  // Storage has no reset; contents are only meaningful below level.
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end
endmodule

// File: doc/st_fifo_8.md
Name: st_fifo_8

Overview:
- Synchronous show-ahead FIFO with Avalon-ST valid/ready on both sides.
- Placed directly upstream of each 8-bit stream sink (in0/in1/in2) of the my_module processing core.
- Decouples external byte producers from the core's back-pressure.
- Three instances in the exam top, one per channel; out_* connects to my_module_0_inN_*.

Parameters:
DATA_W, 8, payload width in bits
DEPTH, 8, number of storage entries; power of two, >= 2
CNT_W, $clog2(DEPTH)+1, width of level output (derived, not overridden)

Ports:
clk  input  1  system clock, all logic on rising edge
rst  input  1  synchronous active-high reset
flush  input  1  synchronous clear of contents, same effect as rst on FIFO state
in_data  input  DATA_W  upstream payload
in_valid  input  1  upstream payload valid
in_ready  output  1  FIFO can accept a word this cycle
out_data  output  DATA_W  head-of-FIFO payload to downstream sink
out_valid  output  1  head word present
out_ready  input  1  downstream sink accepts head word
level  output  CNT_W  number of stored words, 0..DEPTH
full  output  1  level == DEPTH
empty  output  1  level == 0

Behaviour:
- Reset (rst=1 at clock edge):
  - rd_ptr, wr_ptr and level cleared to 0; out_valid=0, full=0, empty=1, in_ready=1.
  - out_data is don't-care while out_valid=0; implement as 0 after reset.
  - Storage array is not cleared.
- Handshakes:
  - Write on cycle where in_valid && in_ready.
  - Read on cycle where out_valid && out_ready.
- in_ready = !full. Registered-state derived only, no combinational path from out_ready. A read at full does not enable a write in the same cycle.
- out_valid = !empty. out_data = mem[rd_ptr] (show-ahead; head word visible without a request).
- Latency and ordering:
  - A word written at edge N appears on out_data/out_valid after edge N (visible in cycle N+1). No same-cycle bypass when empty.
  - Strict FIFO order; no word lost or duplicated.
- Pointers:
  - log2(DEPTH) bits each, wrap naturally from DEPTH-1 to 0.
  - level tracks occupancy separately: +1 on write only, -1 on read only, unchanged on simultaneous read+write or idle.
- Simultaneous read+write when 0 < level < DEPTH: both pointers advance, level unchanged.
- At level == DEPTH: in_ready=0, so in_valid is ignored. A read is allowed and level drops to DEPTH-1.
- At level == 0: out_valid=0, so out_ready is ignored. A write is allowed and level rises to 1.
- Stability: while out_valid=1 and out_ready=0, out_data and out_valid hold unchanged (Avalon-ST source rule).
- Upstream protocol: the upstream may hold in_valid high across cycles with in_ready=0; the word is taken on the first cycle in_ready=1.
- flush:
  - Same as rst for pointers, level and out_valid; any write or read in the same cycle is discarded.
  - rst has priority over flush; flush has priority over handshakes.
- Reset or flush mid-stream: all stored words discarded. The next written word is the first one output.
- full/empty/level are registered-state derived and consistent with each other every cycle.

Test Plan:
- Reset, then write 0x11,0x22,0x33 with out_ready=0 -> level=3, out_valid=1, out_data=0x11 held stable; then out_ready=1 for 3 cycles -> outputs 0x11,0x22,0x33 in order, then empty=1, level=0.
- Fill DEPTH=8 words 0x00..0x07, keep in_valid=1 with in_data=0x08 -> full=1, in_ready=0, 0x08 not stored. Pulse one read -> 0x00 consumed, level=7, in_ready=1. 0x08 is written on the next edge and later read as the 9th word.
- Streaming with in_valid=1 and out_ready=1 continuously at level=1, 20 words 0x40..0x53 -> level stays 1, output is a one-cycle-delayed exact copy, pointers wrap twice, no gaps.
- Empty FIFO, write 0xA5 at edge N with out_ready=1 -> out_valid=0 during cycle N, out_valid=1 and out_data=0xA5 in cycle N+1.
- Load 5 words, assert flush together with in_valid=1 (0xEE) and out_ready=1 -> next cycle level=0, empty=1, out_valid=0; 0xEE not stored. Repeat with rst instead of flush -> same result.
- Random in_valid/out_ready (50%/30%), 1000 words, scoreboard -> order preserved, level matches model every cycle, out_data stable whenever out_valid && !out_ready.
